mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum cycles a granted access may stay outstanding before abort.
REQ-002 clk  in  1  single system clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 a_address  in  27; a_data  in  32; a_we  in  1; a_start  in  1: port A (instruction fetch) request; start is a level.
REQ-005 a_busy  out  1; a_done  out  1; a_err  out  1; a_q  out  32: port A status and read data.
REQ-006 b_address, b_data, b_we, b_start, b_busy, b_done, b_err, b_q: port B (data/DMA), same widths as port A.
REQ-007 mem_address  out  27; mem_data  out  32; mem_we  out  1; mem_start  out  1: to the memory unit.
REQ-008 mem_busy  in  1; mem_q  in  32; mem_init_done  in  1: from the memory unit.

Function
REQ-009 States: IDLE, ISSUE, WAIT, DONE; registered one-hot or binary; no other states reachable.
REQ-010 IDLE: no grant while mem_init_done=0; requests stay pending.
REQ-011 IDLE: a port is eligible when its start=1 and it is not in holdoff (REQ-019).
REQ-012 Single eligible port is granted; if both are eligible, the port not granted last wins; last_grant resets to B, so A wins the first tie.
REQ-013 On grant, the port's address/data/we are registered into mem_address/mem_data/mem_we, the port's busy=1, last_grant updates, state -> ISSUE.
REQ-014 mem_start=1 exactly in ISSUE and WAIT, decoded from the state register; mem_address/data/we stay stable from grant until DONE.
REQ-015 ISSUE: mem_busy=1 sampled -> WAIT; otherwise stay.
REQ-016 WAIT: mem_busy=0 sampled -> DONE; same edge: granted port q <= mem_q, done <= 1.
REQ-017 DONE lasts one cycle: done=1, busy=0, mem_start=0; -> IDLE.
REQ-018 Fast path: a completed access takes 3 cycles from the grant edge to the done pulse (ISSUE 1, WAIT >=1, DONE 1).
REQ-019 Holdoff: the completing port is ineligible in the cycle after DONE; the requester drops start on done; start still high after holdoff is a new request.
REQ-020 Watchdog: a counter clears on grant and increments in ISSUE/WAIT; when it reaches TIMEOUT, -> DONE with err=1 and done=1 for that port, q unchanged.
REQ-021 err is valid only with done; it is 0 otherwise.
REQ-022 The non-granted port's busy stays 0 while its request pends; its start is ignored until the next IDLE arbitration.
REQ-023 A start deasserted before grant cancels the request without side effects.
REQ-024 The watchdog counter is wide enough for TIMEOUT and saturates; it never wraps.

Reset
REQ-025 Reset returns state to IDLE.
REQ-026 Reset clears all busy/done/err outputs, mem_start, mem_we and the watchdog counter to 0.
REQ-027 Reset clears a_q, b_q, mem_address and mem_data to 0 and sets last_grant to B.
REQ-028 Reset mid-access drops mem_start on the next cycle; no done pulse is generated for the aborted access.

Structure
REQ-029 The shared package holds state encodings, the TIMEOUT default and the port-select encoding (A=0, B=1).
REQ-030 One sub-module, mem_arbiter_port, is instantiated twice and holds the per-port q/busy/done/err registers and the holdoff flag.
REQ-031 The arbitration and state machine live in mem_arbiter.

Verification
REQ-032 A reads 0x000010; memory model holds busy 4 cycles and returns 0xDEADBEEF -> a_q=0xDEADBEEF, a_done is a 1-cycle pulse, mem_start held high until mem_busy falls.
REQ-033 A and B start in the same cycle, three times back-to-back -> grant order A,B,A,B,A,B, and each port's done occurs once per request.
REQ-034 B writes 0x12345678 to 0xC00010 -> mem_we=1 and mem_data=0x12345678 stable for the whole ISSUE/WAIT window; b_q unchanged.
REQ-035 TIMEOUT=15, model never raises mem_busy -> b_done=1 and b_err=1 in exactly one cycle; arbiter returns to IDLE.
REQ-036 mem_init_done=0 while A requests -> no mem_start; grant in the cycle after mem_init_done rises.
REQ-037 Reset asserted in WAIT -> next cycle mem_start=0, all busy/done=0; no spurious done after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   state_t    - arbiter state encoding (IDLE, ISSUE, WAIT, DONE)
//   port_sel_t - port-select encoding (A=0, B=1)
//   TIMEOUT_DEFAULT and the address/data widths used by both ports.
package mem_arbiter_pkg;

    localparam int TIMEOUT_DEFAULT = 1023;
    localparam int ADDR_W          = 27;
    localparam int DATA_W          = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_t;

endpackage

// File: rtl/mem_arbiter_port.sv
// mem_arbiter_port
// Per-port status registers of the memory arbiter.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   grant          - this port wins arbitration at this edge (sets busy)
//   finish         - this port's access ends at this edge (enters DONE)
//   abort          - the ending access was cut off by the watchdog
//   load_q         - capture mem_q into q when finishing (completed reads)
//   mem_q          - read data from the memory unit
//   q              - last read data returned to the requester
//   busy/done/err  - access outstanding / one-cycle completion / error flag
//   holdoff        - high for the cycle after DONE; port is not eligible then
module mem_arbiter_port
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              grant,
    input  logic              finish,
    input  logic              abort,
    input  logic              load_q,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              holdoff
);

    // done and err are single-cycle pulses; holdoff trails done by one cycle
    // so the requester has time to drop start before it could be re-granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            holdoff <= 1'b0;
        end else begin
            holdoff <= done;
            done    <= finish;
            err     <= finish & abort;
            if (grant) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
            if (finish && load_q) begin
                q <= mem_q;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter in front of a single memory unit. Port A (instruction
// fetch) and port B (data/DMA) issue level-sensitive requests; ties go to
// the port that was not granted last. A watchdog aborts accesses that stay
// outstanding for TIMEOUT cycles and reports them with err alongside done.
// Ports:
//   clk, reset                         - system clock, synchronous active-high reset
//   a_address/a_data/a_we/a_start      - port A request
//   a_busy/a_done/a_err/a_q            - port A status and read data
//   b_*                                - port B, same as port A
//   mem_address/mem_data/mem_we/mem_start - command to the memory unit
//   mem_busy/mem_q/mem_init_done       - status and read data from the memory unit
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_we,
    input  logic              a_start,
    output logic              a_busy,
    output logic              a_done,
    output logic              a_err,
    output logic [DATA_W-1:0] a_q,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_we,
    input  logic              b_start,
    output logic              b_busy,
    output logic              b_done,
    output logic              b_err,
    output logic [DATA_W-1:0] b_q,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_start,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              mem_init_done
);

    // Counter width covers TIMEOUT itself so the saturation value is never
    // below the abort threshold.
    localparam int            CW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_MAX   = '1;

    state_t        state;
    port_sel_t     last_grant;
    port_sel_t     sel;
    logic [CW-1:0] wd_count;

    logic      a_holdoff, b_holdoff;
    logic      a_elig, b_elig;
    logic      can_grant;
    port_sel_t pick;
    logic      active, timeout_hit, complete_ok, abort, finish, load_q;
    logic      grant_a, grant_b, finish_a, finish_b;

    // The watchdog fires on the edge where the count would reach TIMEOUT,
    // so an access is outstanding for at most TIMEOUT cycles. A normal
    // completion on that same edge takes precedence over the abort.
    always_comb begin
        a_elig      = a_start & ~a_holdoff;
        b_elig      = b_start & ~b_holdoff;
        can_grant   = (state == IDLE) && mem_init_done && (a_elig || b_elig);
        pick        = PORT_A;
        if (a_elig && b_elig) begin
            pick = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (b_elig) begin
            pick = PORT_B;
        end
        active      = (state == ISSUE) || (state == WAIT);
        timeout_hit = active && (wd_count >= WD_LIMIT);
        complete_ok = (state == WAIT) && !mem_busy;
        abort       = timeout_hit && !complete_ok;
        finish      = complete_ok || abort;
        load_q      = !abort && !mem_we;
        grant_a     = can_grant && (pick == PORT_A);
        grant_b     = can_grant && (pick == PORT_B);
        finish_a    = finish && (sel == PORT_A);
        finish_b    = finish && (sel == PORT_B);
    end

    assign mem_start = active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= PORT_B;
            sel         <= PORT_A;
            wd_count    <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_we      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        sel        <= pick;
                        last_grant <= pick;
                        wd_count   <= '0;
                        state      <= ISSUE;
                        if (pick == PORT_A) begin
                            mem_address <= a_address;
                            mem_data    <= a_data;
                            mem_we      <= a_we;
                        end else begin
                            mem_address <= b_address;
                            mem_data    <= b_data;
                            mem_we      <= b_we;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (wd_count != WD_MAX) begin
                        wd_count <= wd_count + CW'(1);
                    end
                    if (finish) begin
                        state <= DONE;
                    end else if (state == ISSUE && mem_busy) begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_arbiter_port u_port_a (
        .clk     (clk),
        .reset   (reset),
        .grant   (grant_a),
        .finish  (finish_a),
        .abort   (abort),
        .load_q  (load_q),
        .mem_q   (mem_q),
        .q       (a_q),
        .busy    (a_busy),
        .done    (a_done),
        .err     (a_err),
        .holdoff (a_holdoff)
    );

    mem_arbiter_port u_port_b (
        .clk     (clk),
        .reset   (reset),
        .grant   (grant_b),
        .finish  (finish_b),
        .abort   (abort),
        .load_q  (load_q),
        .mem_q   (mem_q),
        .q       (b_q),
        .busy    (b_busy),
        .done    (b_done),
        .err     (b_err),
        .holdoff (b_holdoff)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter built with TIMEOUT=15. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] a_address, b_address, mem_address;
    logic [31:0] a_data, b_data, mem_data, a_q, b_q, mem_q;
    logic        a_we, a_start, a_busy, a_done, a_err;
    logic        b_we, b_start, b_busy, b_done, b_err;
    logic        mem_we, mem_start, mem_busy, mem_init_done;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .a_address     (a_address),
        .a_data        (a_data),
        .a_we          (a_we),
        .a_start       (a_start),
        .a_busy        (a_busy),
        .a_done        (a_done),
        .a_err         (a_err),
        .a_q           (a_q),
        .b_address     (b_address),
        .b_data        (b_data),
        .b_we          (b_we),
        .b_start       (b_start),
        .b_busy        (b_busy),
        .b_done        (b_done),
        .b_err         (b_err),
        .b_q           (b_q),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_we        (mem_we),
        .mem_start     (mem_start),
        .mem_busy      (mem_busy),
        .mem_q         (mem_q),
        .mem_init_done (mem_init_done)
    );

    // Memory model for one access: waits for mem_start, holds mem_busy for
    // 'hold' cycles, then returns qv. Returns on the falling edge of the DONE
    // cycle. ms counts cycles seen with mem_start high.
    task automatic mem_access(input int hold, input logic [31:0] qv,
                              output int ms, output bit stable, output bit ok,
                              output logic [26:0] addr);
        logic [26:0] a0;
        logic [31:0] d0;
        logic        w0;
        ok = 1'b0; ms = 0; stable = 1'b1; addr = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_start === 1'b1) break;
        end
        if (mem_start !== 1'b1) return;
        a0 = mem_address; d0 = mem_data; w0 = mem_we; addr = a0;
        ms = 1;
        mem_busy = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (mem_start === 1'b1) ms++;
            if (mem_address !== a0 || mem_data !== d0 || mem_we !== w0) stable = 1'b0;
        end
        mem_busy = 1'b0;
        mem_q    = qv;
        @(negedge clk);
        ok = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({a_busy, a_done, a_err, b_busy, b_done, b_err} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000", {a_busy, a_done, a_err, b_busy, b_done, b_err});
        else passes++;
        checks++; if ({mem_start, mem_we} !== 2'b00)
            $display("[TB] FAIL reset_mem_ctrl: got %b expected 00", {mem_start, mem_we});
        else passes++;
        checks++; if (a_q !== 32'h0 || b_q !== 32'h0)
            $display("[TB] FAIL reset_q: got a=%h b=%h expected 0", a_q, b_q);
        else passes++;
        checks++; if (mem_address !== 27'h0 || mem_data !== 32'h0)
            $display("[TB] FAIL reset_mem_bus: got addr=%h data=%h expected 0", mem_address, mem_data);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_read_a();
        int ms; bit stable, ok; logic [26:0] addr;
        a_address = 27'h000010; a_data = 32'h0; a_we = 1'b0; a_start = 1'b1;
        mem_access(4, 32'hDEADBEEF, ms, stable, ok, addr);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL read_a_grant: got no mem_start expected grant");
        else passes++;
        checks++; if (addr !== 27'h000010) $display("[TB] FAIL read_a_addr: got %h expected 000010", addr);
        else passes++;
        checks++; if (ms !== 5) $display("[TB] FAIL read_a_start_cycles: got %0d expected 5", ms);
        else passes++;
        checks++; if ({a_done, a_busy, a_err, mem_start} !== 4'b1000)
            $display("[TB] FAIL read_a_done_cycle: got %b expected 1000", {a_done, a_busy, a_err, mem_start});
        else passes++;
        checks++; if (a_q !== 32'hDEADBEEF) $display("[TB] FAIL read_a_q: got %h expected deadbeef", a_q);
        else passes++;
        a_start = 1'b0;
        @(negedge clk);
        checks++; if (a_done !== 1'b0) $display("[TB] FAIL read_a_pulse: got %b expected 0", a_done);
        else passes++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int ms; bit stable, ok; logic [26:0] addr;
        int rem_a, rem_b;
        logic [26:0] exp_addr;
        do_reset();
        a_address = 27'h100; a_we = 1'b0;
        b_address = 27'h200; b_we = 1'b0;
        rem_a = 3; rem_b = 3;
        a_start = 1'b1; b_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_addr = (i % 2 == 0) ? 27'h100 : 27'h200;
            mem_access(1, 32'h1000 + i, ms, stable, ok, addr);
            checks++; if (ok !== 1'b1 || addr !== exp_addr)
                $display("[TB] FAIL b2b_order_%0d: got ok=%0d addr=%h expected addr=%h", i, ok, addr, exp_addr);
            else passes++;
            checks++; if ({a_done, b_done} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("[TB] FAIL b2b_done_%0d: got a=%b b=%b expected port %s", i, a_done, b_done, (i % 2 == 0) ? "A" : "B");
            else passes++;
            if (a_done) begin a_start = 1'b0; rem_a--; end
            if (b_done) begin b_start = 1'b0; rem_b--; end
            @(negedge clk);
            if (rem_a > 0) a_start = 1'b1;
            if (rem_b > 0) b_start = 1'b1;
        end
        checks++; if (a_q !== 32'h1004 || b_q !== 32'h1005)
            $display("[TB] FAIL b2b_q: got a=%h b=%h expected 1004/1005", a_q, b_q);
        else passes++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_b();
        int ms; bit stable, ok; logic [26:0] addr;
        b_address = 27'hC00010; b_data = 32'h12345678; b_we = 1'b1; b_start = 1'b1;
        mem_access(3, 32'hAAAA5555, ms, stable, ok, addr);
        checks++; if (ok !== 1'b1 || addr !== 27'hC00010)
            $display("[TB] FAIL write_b_addr: got ok=%0d addr=%h expected c00010", ok, addr);
        else passes++;
        checks++; if (stable !== 1'b1 || ms !== 4)
            $display("[TB] FAIL write_b_stable: got stable=%0d cycles=%0d expected 1/4", stable, ms);
        else passes++;
        checks++; if (mem_we !== 1'b1 || mem_data !== 32'h12345678)
            $display("[TB] FAIL write_b_bus: got we=%b data=%h expected 1/12345678", mem_we, mem_data);
        else passes++;
        checks++; if (b_done !== 1'b1 || b_q !== 32'h1005)
            $display("[TB] FAIL write_b_q: got done=%b q=%h expected 1/00001005", b_done, b_q);
        else passes++;
        b_start = 1'b0; b_we = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int ms, errc, donec, err_alone;
        ms = 0; errc = 0; donec = 0; err_alone = 0;
        mem_busy = 1'b0;
        b_address = 27'h40; b_we = 1'b0; b_start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (mem_start === 1'b1) ms++;
            if (b_err === 1'b1) errc++;
            if (b_err === 1'b1 && b_done !== 1'b1) err_alone++;
            if (b_done === 1'b1) begin donec++; b_start = 1'b0; end
        end
        checks++; if (ms !== 15) $display("[TB] FAIL timeout_window: got %0d expected 15", ms);
        else passes++;
        checks++; if (donec !== 1 || errc !== 1 || err_alone !== 0)
            $display("[TB] FAIL timeout_err_pulse: got done=%0d err=%0d lone_err=%0d expected 1/1/0", donec, errc, err_alone);
        else passes++;
        checks++; if (b_q !== 32'h1005 || mem_start !== 1'b0 || b_busy !== 1'b0)
            $display("[TB] FAIL timeout_idle: got q=%h start=%b busy=%b expected 00001005/0/0", b_q, mem_start, b_busy);
        else passes++;
    endtask

    task automatic test_init_wait();
        int seen;
        seen = 0;
        mem_init_done = 1'b0;
        a_address = 27'h80; a_we = 1'b0; a_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_start !== 1'b0 || a_busy !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) $display("[TB] FAIL init_hold: got %0d active cycles expected 0", seen);
        else passes++;
        mem_init_done = 1'b1;
        @(negedge clk);
        checks++; if (mem_start !== 1'b1 || a_busy !== 1'b1 || mem_address !== 27'h80)
            $display("[TB] FAIL init_grant: got start=%b busy=%b addr=%h expected 1/1/80", mem_start, a_busy, mem_address);
        else passes++;
        mem_busy = 1'b1;
        @(negedge clk);
        mem_busy = 1'b0; mem_q = 32'h55AA;
        @(negedge clk);
        checks++; if (a_done !== 1'b1 || a_q !== 32'h55AA)
            $display("[TB] FAIL init_done: got done=%b q=%h expected 1/000055aa", a_done, a_q);
        else passes++;
        a_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int spurious;
        spurious = 0;
        a_address = 27'h90; a_we = 1'b0; a_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_start === 1'b1) break;
        end
        mem_busy = 1'b1;
        @(negedge clk);
        checks++; if (mem_start !== 1'b1) $display("[TB] FAIL rst_wait_active: got %b expected 1", mem_start);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({mem_start, a_busy, a_done, b_busy, b_done} !== 5'b0)
            $display("[TB] FAIL rst_wait_clear: got %b expected 00000", {mem_start, a_busy, a_done, b_busy, b_done});
        else passes++;
        reset = 1'b0; a_start = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_done !== 1'b0 || b_done !== 1'b0 || mem_start !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) $display("[TB] FAIL rst_wait_spurious: got %0d cycles expected 0", spurious);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_address = '0; a_data = '0; a_we = 1'b0; a_start = 1'b0;
        b_address = '0; b_data = '0; b_we = 1'b0; b_start = 1'b0;
        mem_busy = 1'b0; mem_q = '0; mem_init_done = 1'b1;
        test_reset();
        test_read_a();
        test_back_to_back();
        test_write_b();
        test_timeout();
        test_init_wait();
        test_reset_in_wait();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
